l2_response_receiver: RTL

L2_RESPONSE_RECEIVER -- requirements
Module: l2_response_receiver

---
 rtl/l2_response_receiver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/l2_response_receiver.sv
// L2 response receiver: filters L2 responses for this core, queues them in a 4-entry FIFO and
// replays each as L1 data/tag writes plus a completion notice. L2RSP_RX_STATS_EN adds counters.
package l2_response_receiver_pkg;
    localparam int CORE_INDEX_WIDTH = 2;
    localparam int NUM_CORES        = 1 << CORE_INDEX_WIDTH;

    typedef enum logic [1:0] {
        LOAD_ACK    = 2'd0,
        STORE_ACK   = 2'd1,
        DINVALIDATE = 2'd2,
        IINVALIDATE = 2'd3
    } l2rsp_op_t;

    typedef struct packed {
        logic                        valid;
        logic [CORE_INDEX_WIDTH-1:0] core;
        l2rsp_op_t                   op;
        logic [1:0]                  unit;
        logic [1:0]                  strand;
        logic                        status;
        logic [25:0]                 address;
        logic [NUM_CORES*2-1:0]      way;
        logic [NUM_CORES-1:0]        update;
        logic [511:0]                data;
    } l2rsp_packet_t;
endpackage

module l2_response_receiver
    import l2_response_receiver_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORE_INDEX_WIDTH-1:0] core_id,
    input  l2rsp_packet_t               l2rsp_packet,
    output logic                        l1_wr_en,
    output logic [1:0]                  l1_wr_unit,
    output logic [1:0]                  l1_wr_way,
    output logic [5:0]                  l1_wr_set,
    output logic [1:0]                  l1_wr_beat,
    output logic [127:0]                l1_wr_data,
    output logic                        l1_tag_wr_en,
    output logic                        l1_tag_valid,
    output logic [19:0]                 l1_tag,
    output logic                        done_valid,
    output logic [1:0]                  done_unit,
    output logic [1:0]                  done_strand,
    output logic                        done_status,
    output logic [1:0]                  done_op,
    output logic                        fifo_overflow
`ifdef L2RSP_RX_STATS_EN
    ,
    output logic [31:0]                 stat_accepted,
    output logic [31:0]                 stat_dropped
`endif
);
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        l2rsp_op_t    op;
        logic [1:0]   unit;
        logic [1:0]   strand;
        logic         status;
        logic [25:0]  address;
        logic [1:0]   way;
        logic         update;
        logic [511:0] data;
        logic         notify;
    } rx_entry_t;

    typedef enum logic [1:0] {IDLE, DATA, TAG, NOTIFY} state_t;

    state_t     state, state_next;
    rx_entry_t  fifo_mem [FIFO_DEPTH];
    rx_entry_t  cur, head, incoming;
    logic [1:0] wr_ptr, rd_ptr, beat;
    logic [2:0] count;
    logic       own, upd, push_req, notify_in, push, pop, full, drop;

    function automatic logic has_data(input rx_entry_t e);
        return (e.op == LOAD_ACK) || (e.op == STORE_ACK && e.update);
    endfunction

    // First stage after the data beats (or after the pop when there are none).
    function automatic state_t after_data(input rx_entry_t e);
        if (e.op != STORE_ACK) return TAG;
        else if (e.notify)     return NOTIFY;
        else                   return IDLE;
    endfunction

    assign own = (l2rsp_packet.core == core_id);
    assign upd = l2rsp_packet.update[core_id];

    always_comb begin
        push_req  = 1'b0;
        notify_in = 1'b0;
        if (l2rsp_packet.valid) begin
            case (l2rsp_packet.op)
                LOAD_ACK:    begin push_req = own;       notify_in = own; end
                STORE_ACK:   begin push_req = own | upd; notify_in = own; end
                DINVALIDATE: push_req = upd;
                IINVALIDATE: push_req = 1'b1;
                default:     push_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        incoming.op      = l2rsp_packet.op;
        incoming.unit    = (l2rsp_packet.op == IINVALIDATE) ? 2'd0 : l2rsp_packet.unit;
        incoming.strand  = l2rsp_packet.strand;
        incoming.status  = l2rsp_packet.status;
        incoming.address = l2rsp_packet.address;
        incoming.way     = l2rsp_packet.way[{core_id, 1'b0} +: 2];
        incoming.update  = upd;
        incoming.data    = l2rsp_packet.data;
        incoming.notify  = notify_in;
    end

    // A full FIFO still accepts when the FSM pops in the same cycle.
    assign head = fifo_mem[rd_ptr];
    assign full = (count == 3'(FIFO_DEPTH));
    assign pop  = (state == IDLE) && (count != 3'd0);
    assign push = push_req && (!full || pop);
    assign drop = push_req && !push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            count         <= 3'd0;
            fifo_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
            if (drop) fifo_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= incoming;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cur   <= '0;
            beat  <= 2'd0;
        end else begin
            state <= state_next;
            if (pop) cur <= head;
            beat <= (state == DATA) ? beat + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_next   = state;
        l1_wr_en     = 1'b0;
        l1_wr_unit   = 2'd0;
        l1_wr_way    = 2'd0;
        l1_wr_set    = 6'd0;
        l1_wr_beat   = 2'd0;
        l1_wr_data   = '0;
        l1_tag_wr_en = 1'b0;
        l1_tag_valid = 1'b0;
        l1_tag       = 20'd0;
        done_valid   = 1'b0;
        done_unit    = 2'd0;
        done_strand  = 2'd0;
        done_status  = 1'b0;
        done_op      = 2'd0;
        case (state)
            IDLE: begin
                if (pop) state_next = has_data(head) ? DATA : after_data(head);
            end
            DATA: begin
                l1_wr_en   = 1'b1;
                l1_wr_unit = cur.unit;
                l1_wr_way  = cur.way;
                l1_wr_set  = cur.address[5:0];
                l1_wr_beat = beat;
                l1_wr_data = cur.data[{beat, 7'd0} +: 128];
                if (beat == 2'd3) state_next = after_data(cur);
            end
            TAG: begin
                l1_tag_wr_en = 1'b1;
                l1_wr_unit   = cur.unit;
                l1_wr_way    = cur.way;
                l1_wr_set    = cur.address[5:0];
                l1_tag       = cur.address[25:6];
                l1_tag_valid = (cur.op == LOAD_ACK);
                state_next   = cur.notify ? NOTIFY : IDLE;
            end
            NOTIFY: begin
                done_valid  = 1'b1;
                done_unit   = cur.unit;
                done_strand = cur.strand;
                done_status = cur.status;
                done_op     = cur.op;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef L2RSP_RX_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_accepted <= 32'd0;
            stat_dropped  <= 32'd0;
        end else begin
            if (push) stat_accepted <= stat_accepted + 32'd1;
            if (drop) stat_dropped  <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule
